// File: rtl/nibble_serial_adder.sv
// Nibble-serial WIDTH-bit adder: one 4-bit lookahead slice per cycle, LSB nibble first.
// Define NIBBLE_SERIAL_ADDER_OVF_EN to add a registered two's-complement overflow output.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nx;
  logic             c0;
  logic [IW-1:0]    idx;

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] s;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic       last;

  always_comb begin
    g  = ar[3:0] & br[3:0];
    p  = ar[3:0] ^ br[3:0];
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
       | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
       | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    s  = p ^ {c3, c2, c1, c0};
    acc_nx = acc;
    acc_nx[{idx, 2'b00} +: 4] = s;
    last = (idx == IW'(NIB - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      acc       <= '0;
      ar        <= '0;
      br        <= '0;
      c0        <= 1'b0;
      idx       <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            ar       <= a;
            br       <= b;
            c0       <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          c0  <= c4;
          ar  <= ar >> 4;
          br  <= br >> 4;
          idx <= idx + 1'b1;
          if (last) begin
            sum       <= acc_nx;
            cout      <= c4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
            ovf       <= c3 ^ c4;
`endif
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; no same-edge re-accept
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16): vector table
// plus backpressure and reset corner sequences.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one add with fixed-latency checks, then consumes the result
  task automatic do_op(input string nm, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic vc,
                       input logic [W-1:0] es, input logic ec,
                       input logic eo);
    chk({nm, ".ready_pre"}, 32'(in_ready), 32'd1);
    a = va;
    b = vb;
    cin = vc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({nm, ".busy"}, 32'(in_ready), 32'd0);
    for (int k = 1; k < NIB; k++) begin
      chk({nm, ".early_valid"}, 32'(out_valid), 32'd0);
      tick();
    end
    chk({nm, ".no_valid_e3"}, 32'(out_valid), 32'd0);
    tick();
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".ready_done"}, 32'(in_ready), 32'd0);
    chk({nm, ".sum"}, 32'(sum), 32'(es));
    chk({nm, ".cout"}, 32'(cout), 32'(ec));
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    chk({nm, ".ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unreachable");
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, ".idle_ready"}, 32'(in_ready), 32'd1);
    chk({nm, ".idle_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vt[4] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[6] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vt[7] = '{16'h8001, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0};

    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(sum), 32'd0);
    chk("rst.cout", 32'(cout), 32'd0);

    for (int i = 0; i < 8; i++) begin
      do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin,
            vt[i].esum, vt[i].ecout, vt[i].eovf);
      tick();
    end

    // Backpressure: result held, new operands ignored
    a = 16'h1111;
    b = 16'h2222;
    cin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (NIB) tick();
    chk("bp.valid", 32'(out_valid), 32'd1);
    chk("bp.sum0", 32'(sum), 32'h3333);
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_sum", 32'(sum), 32'h3333);
      chk("bp.hold_cout", 32'(cout), 32'd0);
      chk("bp.hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp.rel_ready", 32'(in_ready), 32'd1);
    chk("bp.rel_valid", 32'(out_valid), 32'd0);
    chk("bp.rel_sum", 32'(sum), 32'h3333);
    repeat (NIB + 1) tick();
    chk("bp.no_capture", 32'(out_valid), 32'd0);
    do_op("bp.next", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Reset at the edge where the nibble index is 2
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid.out_valid", 32'(out_valid), 32'd0);
    chk("mid.sum", 32'(sum), 32'd0);
    chk("mid.cout", 32'(cout), 32'd0);
    chk("mid.in_ready", 32'(in_ready), 32'd1);
    repeat (NIB + 1) tick();
    chk("mid.abandoned", 32'(out_valid), 32'd0);
    do_op("mid.after", 16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Reset coincident with an input handshake: nothing captured
    a = 16'h0001;
    b = 16'h0001;
    cin = 1'b0;
    in_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    chk("rsths.ready", 32'(in_ready), 32'd1);
    repeat (NIB + 1) tick();
    chk("rsths.no_op", 32'(out_valid), 32'd0);
    chk("rsths.sum", 32'(sum), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Sequential operand-staging and accumulation stage that performs one WIDTH-bit add.
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Adds one 4-bit nibble per cycle, least-significant nibble first, using an internal 4-bit carry-lookahead slice, with the inter-nibble carry held in a register.
- Presents the full sum and carry-out over a second valid/ready handshake to the consumer downstream.

Parameters:
- WIDTH, 16: operand and sum width in bits; must be a multiple of 4 and at least 4.
- NIB (localparam), WIDTH/4: number of nibble cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset.
- in_valid  input  1  operands a, b, cin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  addend.
- b  input  WIDTH  addend.
- cin  input  1  carry into bit 0.
- out_valid  output  1  sum and cout are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  registered result.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is synchronous and active-low, rst_n, sampled only on the rising edge of clk.
- Reset values: state=IDLE, out_valid=0, sum=0, cout=0, carry reg=0, nibble index=0. in_ready is 1 in the first cycle after reset.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at an edge, capture a, b into operand shift registers, load carry reg with cin, set index to 0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, add the current low nibbles ai[3:0], bi[3:0] with carry reg c0.
    - Slice equations: g=ai&bi; p=ai^bi; c1=g0|p0c0; c2=g1|p1g0|p1p0c0; c3=g2|p2g1|p2p1g0|p2p1p0c0; c4=g3|p3g2|p3p2g1|p3p2p1g0|p3p2p1p0c0; s=p^{c3,c2,c1,c0}.
    - At the edge: write s into the internal result accumulator at nibble position index, load carry reg with c4, shift operands right by 4, increment index.
    - When index==NIB-1 at the edge: copy the completed accumulator to sum, set cout=c4, set out_valid=1, go to DONE.
  - DONE: out_valid=1, in_ready=0; sum and cout are held stable. On out_ready at an edge, clear out_valid and go to IDLE. There is no same-edge re-acceptance; in_valid is ignored in DONE.
- Latency and throughput:
  - Acceptance at edge E0 gives out_valid high after edge E0+NIB (4 cycles for WIDTH=16).
  - Minimum initiation interval is NIB+2 cycles.
- sum/cout change only at the DONE-entry edge (or reset). Between operations they retain the previous result.
- Arithmetic: unsigned modulo 2^WIDTH. {cout,sum} = a+b+cin exactly.
- Carry propagation across nibble boundaries goes only through the carry reg. No combinational path exists from a/b/cin to any output.
- in_valid while in_ready=0 is ignored; it is not queued.
- Reset mid-operation (RUN or DONE): at the reset edge the operation is abandoned, no result is produced, out_valid=0, sum=0, cout=0, state=IDLE.
- Simultaneous rst_n=0 with a handshake: reset wins; the operands are not captured and the result is not consumed.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Adds output port ovf, 1 bit, registered.
  - ovf = c3^c4 of the final (most-significant) nibble, i.e. two's-complement overflow, loaded at the DONE-entry edge alongside cout.
  - Reset value 0; held with sum.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, cin=0 accepted at E0. Required: in_ready=0 during E0..E0+4; out_valid=1 after E0+4; sum=0x5555, cout=0.
- Full ripple: a=0xFFFF, b=0x0001, cin=0. Required: sum=0x0000, cout=1. Carry crosses all 4 nibble boundaries; same latency as the basic add.
- Carry-in only: a=0xFFFF, b=0x0000, cin=1. Required: sum=0x0000, cout=1. Then a=0x0000, b=0x0000, cin=1 gives sum=0x0001, cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises while driving in_valid=1 with new operands.
  - Required: sum, cout, out_valid stable; in_ready=0; new operands not captured.
  - Assert out_ready: next cycle state is IDLE with in_ready=1.
- Reset mid-RUN: assert rst_n=0 for one edge when index=2. Required: out_valid=0, sum=0, cout=0, in_ready=1 next cycle. A following add 0x0F0F+0x00F1, cin=0 yields sum=0x1000, cout=0.
- Overflow (macro defined):
  - 0x7FFF+0x0001 gives sum=0x8000, cout=0, ovf=1.
  - 0x8000+0x8000 gives sum=0x0000, cout=1, ovf=1.
  - 0xFFFF+0x0001 gives ovf=0.
